// File: rtl/sa_skew_feeder.sv
// Diagonal skew feeder for one systolic-array edge: lane i delays each accepted
// beat by i steps, then drains the pipeline with bubbles and pulses done.
module sa_skew_feeder #(
    parameter int N         = 4,
    parameter int ELEM_BITS = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic                   clear,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N*ELEM_BITS-1:0] in_data,
    input  logic                   in_last,
    output logic [N*ELEM_BITS-1:0] pe_a,
    output logic [N-1:0]           pe_en,
    output logic                   busy,
    output logic                   done
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t                 state, state_next;
    logic [CW-1:0]          count, count_next;
    logic                   done_next;
    logic                   step;
    logic                   step_tag;
    logic [N*ELEM_BITS-1:0] step_data;

    assign in_ready = (state == STREAM);
    assign busy     = (state != IDLE);

    // A beat offered on a clear cycle is dropped, so clear also vetoes the step.
    assign step      = !clear && (((state == STREAM) && in_valid) || (state == DRAIN));
    assign step_tag  = (state == STREAM);
    assign step_data = (state == STREAM) ? in_data : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            count <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            done  <= done_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the case can leave a signal unassigned and infer a latch.
        state_next = state;
        count_next = count;
        done_next  = 1'b0;
        if (clear) begin
            state_next = IDLE;
            count_next = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) state_next = STREAM;
                end
                STREAM: begin
                    if (in_valid && in_last) begin
                        if (N == 1) begin
                            state_next = IDLE;
                            done_next  = 1'b1;
                        end else begin
                            state_next = DRAIN;
                            count_next = CW'(N - 1);
                        end
                    end
                end
                DRAIN: begin
                    count_next = count - CW'(1);
                    if (count == CW'(1)) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [ELEM_BITS-1:0] src_data;
        logic                 src_tag;
        logic [ELEM_BITS-1:0] out_data;
        logic                 out_en;

        if (i == 0) begin : g_direct
            assign src_data = step_data[0 +: ELEM_BITS];
            assign src_tag  = step_tag;
        end else begin : g_chain
            logic [ELEM_BITS-1:0] dly_data [i];
            logic [i-1:0]         dly_tag;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    // NOTE: the delay storage is reset too, because bubbles and
                    // post-reset output must read as defined zeros, not X.
                    for (int j = 0; j < i; j++) dly_data[j] <= '0;
                    dly_tag <= '0;
                end else if (clear) begin
                    dly_tag <= '0;
                end else if (step) begin
                    dly_data[0] <= step_data[i*ELEM_BITS +: ELEM_BITS];
                    dly_tag[0]  <= step_tag;
                    for (int j = 1; j < i; j++) begin
                        dly_data[j] <= dly_data[j-1];
                        dly_tag[j]  <= dly_tag[j-1];
                    end
                end
            end

            assign src_data = dly_data[i-1];
            assign src_tag  = dly_tag[i-1];
        end

        // Output stage: data holds between steps, enable is a one-step strobe.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                out_data <= '0;
                out_en   <= 1'b0;
            end else if (clear) begin
                out_en <= 1'b0;
            end else if (step) begin
                out_data <= src_data;
                out_en   <= src_tag;
            end else begin
                out_en <= 1'b0;
            end
        end

        assign pe_a[i*ELEM_BITS +: ELEM_BITS] = out_data;
        assign pe_en[i]                       = out_en;
    end

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Randomised and directed bench for sa_skew_feeder (N=4 against a beat-history
// model, plus a small directed N=1 instance).
module tb_sa_skew_feeder;

    localparam int N  = 4;
    localparam int EB = 8;
    localparam int W  = N * EB;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic         start, clear, in_valid, in_last;
    logic [W-1:0] in_data;
    logic         in_ready, busy, done;
    logic [W-1:0] pe_a;
    logic [N-1:0] pe_en;

    logic          s_start, s_clear, s_valid, s_last;
    logic [EB-1:0] s_data;
    logic          s_ready, s_busy, s_done;
    logic [EB-1:0] s_pe_a;
    logic [0:0]    s_pe_en;

    sa_skew_feeder #(.N(N), .ELEM_BITS(EB)) dut (
        .clk(clk), .rstn(rstn), .start(start), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .pe_a(pe_a), .pe_en(pe_en), .busy(busy), .done(done)
    );

    sa_skew_feeder #(.N(1), .ELEM_BITS(EB)) dut1 (
        .clk(clk), .rstn(rstn), .start(s_start), .clear(s_clear),
        .in_valid(s_valid), .in_ready(s_ready), .in_data(s_data), .in_last(s_last),
        .pe_a(s_pe_a), .pe_en(s_pe_en), .busy(s_busy), .done(s_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: a history of the last N steps (beats or bubbles).
    // After a step, lane i shows the entry pushed i steps ago.
    typedef enum {M_IDLE, M_STREAM, M_DRAIN} mphase_t;
    typedef struct {
        logic [W-1:0] data;
        logic         tag;
        logic         known;
    } entry_t;

    entry_t        hist[$];
    mphase_t       ph;
    int            bubbles;
    logic [EB-1:0] exp_a [N];
    bit            exp_known [N];
    logic [N-1:0]  exp_en;
    logic          exp_done;

    function automatic void model_reset();
        hist.delete();
        ph       = M_IDLE;
        bubbles  = 0;
        exp_en   = '0;
        exp_done = 1'b0;
        for (int i = 0; i < N; i++) begin
            exp_a[i]     = '0;
            exp_known[i] = 1'b1;
        end
    endfunction

    function automatic void model_update(bit st, bit cl, bit v, logic [W-1:0] d, bit l);
        bit     stepped = 1'b0;
        entry_t e;
        exp_done = 1'b0;
        exp_en   = '0;
        if (cl) begin
            ph = M_IDLE;
            foreach (hist[k]) begin
                hist[k].tag   = 1'b0;
                hist[k].known = 1'b0;
            end
            for (int i = 0; i < N; i++) exp_known[i] = 1'b0;
        end else begin
            case (ph)
                M_IDLE: if (st) ph = M_STREAM;
                M_STREAM: begin
                    if (v) begin
                        e.data = d; e.tag = 1'b1; e.known = 1'b1;
                        hist.push_back(e);
                        stepped = 1'b1;
                        if (l) begin
                            if (N == 1) begin
                                ph       = M_IDLE;
                                exp_done = 1'b1;
                            end else begin
                                ph      = M_DRAIN;
                                bubbles = N - 1;
                            end
                        end
                    end
                end
                M_DRAIN: begin
                    e.data = '0; e.tag = 1'b0; e.known = 1'b1;
                    hist.push_back(e);
                    stepped = 1'b1;
                    bubbles--;
                    if (bubbles == 0) begin
                        ph       = M_IDLE;
                        exp_done = 1'b1;
                    end
                end
                default: ph = M_IDLE;
            endcase
        end
        if (stepped) begin
            for (int i = 0; i < N; i++) begin
                int idx = hist.size() - 1 - i;
                if (idx >= 0) begin
                    exp_a[i]     = hist[idx].data[i*EB +: EB];
                    exp_known[i] = hist[idx].known;
                    exp_en[i]    = hist[idx].tag;
                end else begin
                    exp_a[i]     = '0;
                    exp_known[i] = 1'b1;
                end
            end
        end
        while (hist.size() > N) void'(hist.pop_front());
    endfunction

    task automatic compare_outputs(input string tag);
        check({tag, "_ready"}, in_ready, ph == M_STREAM);
        check({tag, "_busy"},  busy,     ph != M_IDLE);
        check({tag, "_en"},    pe_en,    exp_en);
        check({tag, "_done"},  done,     exp_done);
        for (int i = 0; i < N; i++)
            if (exp_known[i]) check({tag, "_a"}, pe_a[i*EB +: EB], exp_a[i]);
    endtask

    task automatic run_cycle(input string tag, input bit st, input bit cl, input bit v,
                             input logic [W-1:0] d, input bit l);
        start    = st;
        clear    = cl;
        in_valid = v;
        in_data  = d;
        in_last  = l;
        model_update(st, cl, v, d, l);
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        compare_outputs(tag);
    endtask

    function automatic logic [W-1:0] rnd_beat();
        return W'($urandom());
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    logic [W-1:0] beats2 [3] = '{32'h04030201, 32'h14131211, 32'h24232221};
    logic [N-1:0] en2    [7] = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};

    initial begin
        int   drain_cycles;
        bit   done_seen;
        logic [EB-1:0] d1;

        start = 0; clear = 0; in_valid = 0; in_last = 0; in_data = '0;
        s_start = 0; s_clear = 0; s_valid = 0; s_last = 0; s_data = '0;
        model_reset();

        repeat (2) @(negedge clk);
        compare_outputs("reset");
        rstn = 1'b1;
        @(negedge clk);
        compare_outputs("idle");

        // Three back-to-back beats, last on the third.
        run_cycle("t2_start", 1, 0, 0, '0, 0);
        for (int k = 0; k < 7; k++) begin
            if (k < 3) run_cycle("t2", 0, 0, 1, beats2[k], k == 2);
            else       run_cycle("t2", 0, 0, 0, '0, 0);
            check("t2_en_seq", pe_en, en2[k]);
            check("t2_done_seq", done, k == 5);
            if (k >= 3 && k <= 5) check("t2_lane3", pe_a[3*EB +: EB], beats2[k-3][31:24]);
        end

        // Stalled stream: valid 1,0,1,0,1(last).
        run_cycle("t3_start", 1, 0, 0, '0, 0);
        drain_cycles = 0;
        for (int k = 0; k < 5; k++) begin
            run_cycle("t3", 0, 0, (k % 2) == 0, rnd_beat(), k == 4);
            if ((k % 2) == 1) check("t3_stall_en", pe_en, '0);
            if (busy && !in_ready) drain_cycles++;
        end
        for (int k = 0; k < 5; k++) begin
            run_cycle("t3_drain", 0, 0, 0, '0, 0);
            if (busy && !in_ready) drain_cycles++;
        end
        check("t3_drain_cycles", drain_cycles, 3);

        // clear one cycle into DRAIN, then a clean stream.
        run_cycle("t4_start", 1, 0, 0, '0, 0);
        run_cycle("t4", 0, 0, 1, rnd_beat(), 0);
        run_cycle("t4", 0, 0, 1, rnd_beat(), 1);
        run_cycle("t4_drain", 0, 0, 0, '0, 0);
        run_cycle("t4_clear", 0, 1, 0, '0, 0);
        check("t4_clear_busy", busy, 1'b0);
        check("t4_clear_en", pe_en, '0);
        done_seen = done;
        for (int k = 0; k < 4; k++) begin
            run_cycle("t4_after", 0, 0, 0, '0, 0);
            done_seen |= done;
        end
        check("t4_no_done", done_seen, 1'b0);
        run_cycle("t4_restart", 1, 0, 0, '0, 0);
        for (int k = 0; k < 3; k++) run_cycle("t4_new", 0, 0, 1, rnd_beat(), k == 2);
        for (int k = 0; k < 4; k++) run_cycle("t4_new_drain", 0, 0, 0, '0, 0);

        // start during STREAM is ignored; start+clear together clears.
        run_cycle("t5_start", 1, 0, 0, '0, 0);
        run_cycle("t5", 0, 0, 1, rnd_beat(), 0);
        run_cycle("t5_restart", 1, 0, 1, rnd_beat(), 0);
        check("t5_still_stream", in_ready, 1'b1);
        run_cycle("t5_both", 1, 1, 1, rnd_beat(), 0);
        check("t5_clear_wins", busy, 1'b0);
        run_cycle("t5_idle", 0, 0, 0, '0, 0);
        check("t5_idle_ready", in_ready, 1'b0);

        // Reset in the middle of a stream.
        run_cycle("t1_start", 1, 0, 0, '0, 0);
        run_cycle("t1", 0, 0, 1, rnd_beat(), 0);
        run_cycle("t1", 0, 0, 1, rnd_beat(), 0);
        rstn = 1'b0;
        #1;
        check("t1_rst_ready", in_ready, 1'b0);
        check("t1_rst_busy", busy, 1'b0);
        check("t1_rst_en", pe_en, '0);
        check("t1_rst_done", done, 1'b0);
        check("t1_rst_a", pe_a, '0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        compare_outputs("t1_post");

        // Randomised traffic.
        for (int k = 0; k < 1500; k++) begin
            run_cycle("rnd", $urandom_range(0, 3) == 0, $urandom_range(0, 31) == 0,
                      $urandom_range(0, 2) != 0, rnd_beat(), $urandom_range(0, 3) == 0);
        end
        run_cycle("rnd_end", 0, 1, 0, '0, 0);

        // N=1 instance: done and the only enable coincide, no DRAIN.
        d1 = EB'($urandom());
        s_start = 1'b1;
        @(posedge clk); @(negedge clk);
        s_start = 1'b0;
        check("n1_ready", s_ready, 1'b1);
        check("n1_busy", s_busy, 1'b1);
        @(posedge clk); @(negedge clk);
        check("n1_stall_en", s_pe_en, 1'b0);
        s_valid = 1'b1; s_last = 1'b1; s_data = d1;
        @(posedge clk); @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
        check("n1_en", s_pe_en, 1'b1);
        check("n1_done", s_done, 1'b1);
        check("n1_a", s_pe_a, d1);
        check("n1_idle", s_busy, 1'b0);
        check("n1_no_drain", s_ready, 1'b0);
        @(posedge clk); @(negedge clk);
        check("n1_en_after", s_pe_en, 1'b0);
        check("n1_done_after", s_done, 1'b0);
        check("n1_a_hold", s_pe_a, d1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
